// File: rtl/pipelined_cla_subtractor_if.sv
// Handshake and operand/result bundle for the pipelined CLA subtractor.
// The slave side is the subtractor; the master side drives operands and consumes results.
interface pipelined_cla_subtractor_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             bin_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] diff_o;
  logic             bout_o;
  logic             ovf_o;
  logic             zero_o;

  modport slave (
    input  valid_i, a_i, b_i, bin_i, ready_i,
    output ready_o, valid_o, diff_o, bout_o, ovf_o, zero_o
  );

  modport master (
    output valid_i, a_i, b_i, bin_i, ready_i,
    input  ready_o, valid_o, diff_o, bout_o, ovf_o, zero_o
  );
endinterface

// File: rtl/pipelined_cla_subtractor.sv
// Two-stage carry-lookahead subtractor (a - b - bin) with valid/ready flow control.
// Stage 1 resolves the low half and the mid carry; stage 2 the high half and flags.
module pipelined_cla_subtractor #(
  parameter int WIDTH = 32,
  parameter int HALF  = WIDTH / 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  pipelined_cla_subtractor_if.slave bus
);

  // Adds x + y + cin over HALF bits using 4-bit propagate/generate groups;
  // returns {carry_out, sum}. A trailing partial group is handled the same way.
  function automatic logic [HALF:0] cla_add(input logic [HALF-1:0] x,
                                            input logic [HALF-1:0] y,
                                            input logic            cin);
    logic [HALF-1:0] p;
    logic [HALF-1:0] g;
    logic [HALF:0]   c;
    logic            gp;
    logic            gg;
    int              top;
    p    = x ^ y;
    g    = x & y;
    c    = '0;
    c[0] = cin;
    for (int base = 0; base < HALF; base += 4) begin
      gp = 1'b1;
      gg = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (base + k < HALF) begin
          c[base+k] = gg | (gp & c[base]);
          gg        = g[base+k] | (p[base+k] & gg);
          gp        = gp & p[base+k];
        end
      end
      top    = (base + 4 < HALF) ? base + 4 : HALF;
      c[top] = gg | (gp & c[base]);
    end
    return {c[HALF], p ^ c[HALF-1:0]};
  endfunction

  logic             adv1;
  logic             adv2;
  logic             accept;

  logic             v1_q,      v1_d;
  logic [HALF-1:0]  a_hi_q,    a_hi_d;
  logic [HALF-1:0]  b_hi_q,    b_hi_d;
  logic [HALF-1:0]  diff_lo_q, diff_lo_d;
  logic             cmid_q,    cmid_d;

  logic             v2_q,      v2_d;
  logic [WIDTH-1:0] diff_q,    diff_d;
  logic             bout_q,    bout_d;
  logic             ovf_q,     ovf_d;
  logic             zero_q,    zero_d;

  logic [HALF:0]    lo_sum;
  logic [HALF:0]    hi_sum;
  logic [WIDTH-1:0] full_diff;

  assign adv2       = !v2_q || bus.ready_i;
  assign adv1       = !v1_q || adv2;
  assign accept     = bus.valid_i && adv1;
  assign bus.ready_o = adv1;

  // ---- stage 1: low half and mid carry ----
  assign lo_sum = cla_add(bus.a_i[HALF-1:0], ~bus.b_i[HALF-1:0], ~bus.bin_i);

  always_comb begin
    v1_d      = v1_q;
    a_hi_d    = a_hi_q;
    b_hi_d    = b_hi_q;
    diff_lo_d = diff_lo_q;
    cmid_d    = cmid_q;
    if (adv1) begin
      v1_d = bus.valid_i;
    end
    if (accept) begin
      a_hi_d    = bus.a_i[WIDTH-1:HALF];
      b_hi_d    = bus.b_i[WIDTH-1:HALF];
      diff_lo_d = lo_sum[HALF-1:0];
      cmid_d    = lo_sum[HALF];
    end
  end

  // ---- stage 2: high half, borrow, overflow, zero ----
  assign hi_sum    = cla_add(a_hi_q, ~b_hi_q, cmid_q);
  assign full_diff = {hi_sum[HALF-1:0], diff_lo_q};

  always_comb begin
    v2_d   = v2_q;
    diff_d = diff_q;
    bout_d = bout_q;
    ovf_d  = ovf_q;
    zero_d = zero_q;
    if (adv2) begin
      v2_d = v1_q;
    end
    if (adv2 && v1_q) begin
      diff_d = full_diff;
      bout_d = ~hi_sum[HALF];
      ovf_d  = (a_hi_q[HALF-1] ^ b_hi_q[HALF-1]) & (hi_sum[HALF-1] ^ a_hi_q[HALF-1]);
      zero_d = (full_diff == '0);
    end
  end

  // Control and visible outputs clear asynchronously; stage-1 operand data never needs to.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  always_ff @(posedge clk_i) begin
    a_hi_q    <= a_hi_d;
    b_hi_q    <= b_hi_d;
    diff_lo_q <= diff_lo_d;
    cmid_q    <= cmid_d;
  end

  assign bus.valid_o = v2_q;
  assign bus.diff_o  = diff_q;
  assign bus.bout_o  = bout_q;
  assign bus.ovf_o   = ovf_q;
  assign bus.zero_o  = zero_q;

endmodule

// File: tb/tb_pipelined_cla_subtractor.sv
// Directed-vector bench for pipelined_cla_subtractor (WIDTH = 32).
module tb_pipelined_cla_subtractor;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_ni;
  int   errors = 0;
  int   checks = 0;

  pipelined_cla_subtractor_if #(.WIDTH(W)) bus ();

  pipelined_cla_subtractor #(.WIDTH(W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    logic         z;
  } vec_t;

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    bus.valid_i = 1'b1;
    bus.a_i     = a;
    bus.b_i     = b;
    bus.bin_i   = bin;
  endtask

  task automatic test_reset();
    rst_ni      = 1'b1;
    bus.ready_i = 1'b0;
    drive(32'd5, 32'd3, 1'b0);
    #1 rst_ni = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.valid_o); end
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.ready_o); end
    checks++; if (bus.diff_o !== '0) begin errors++; $display("FAIL reset_diff: got %h want 0", bus.diff_o); end
    checks++; if (bus.bout_o !== 1'b0) begin errors++; $display("FAIL reset_bout: got %b want 0", bus.bout_o); end
    checks++; if (bus.ovf_o !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", bus.ovf_o); end
    checks++; if (bus.zero_o !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b want 0", bus.zero_o); end
    bus.valid_i = 1'b0;
    @(negedge clk);
    rst_ni      = 1'b1;
    bus.ready_i = 1'b1;
  endtask

  task automatic test_arith();
    vec_t v[8];
    v[0] = '{32'd5,        32'd3,        1'b0, 32'd2,        1'b0, 1'b0, 1'b0};
    v[1] = '{32'd0,        32'd1,        1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    v[2] = '{32'h80000000, 32'd1,        1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
    v[3] = '{32'h0000FFFF, 32'h0000FFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    v[4] = '{32'h12345678, 32'h12345678, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
    v[5] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0};
    v[6] = '{32'd0,        32'd0,        1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    v[7] = '{32'h00010000, 32'd1,        1'b0, 32'h0000FFFF, 1'b0, 1'b0, 1'b0};
    bus.ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(v[i].a, v[i].b, v[i].bin);
      @(posedge clk);
      #1 bus.valid_i = 1'b0;
      checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL arith%0d_early_valid: got %b want 0", i, bus.valid_o); end
      @(posedge clk);
      #1;
      checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL arith%0d_valid: got %b want 1", i, bus.valid_o); end
      checks++; if (bus.diff_o !== v[i].d) begin errors++; $display("FAIL arith%0d_diff: got %h want %h", i, bus.diff_o, v[i].d); end
      checks++; if (bus.bout_o !== v[i].bo) begin errors++; $display("FAIL arith%0d_bout: got %b want %b", i, bus.bout_o, v[i].bo); end
      checks++; if (bus.ovf_o !== v[i].ov) begin errors++; $display("FAIL arith%0d_ovf: got %b want %b", i, bus.ovf_o, v[i].ov); end
      checks++; if (bus.zero_o !== v[i].z) begin errors++; $display("FAIL arith%0d_zero: got %b want %b", i, bus.zero_o, v[i].z); end
    end
    @(posedge clk);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_d[4];
    exp_d[0] = 32'd9; exp_d[1] = 32'd18; exp_d[2] = 32'd27; exp_d[3] = 32'd36;
    bus.ready_i = 1'b1;
    for (int t = 0; t < 7; t++) begin
      @(negedge clk);
      checks++; if (bus.valid_o !== ((t >= 2 && t <= 5) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL b2b_valid_t%0d: got %b", t, bus.valid_o); end
      if (t >= 2 && t <= 5) begin
        checks++; if (bus.diff_o !== exp_d[t-2]) begin errors++; $display("FAIL b2b_diff_t%0d: got %0d want %0d", t, bus.diff_o, exp_d[t-2]); end
      end
      checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready_t%0d: got %b want 1", t, bus.ready_o); end
      if (t < 4) drive(32'(10 * (t + 1)), 32'(t + 1), 1'b0);
      else bus.valid_i = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    bus.ready_i = 1'b0;
    @(negedge clk);
    drive(32'd100, 32'd1, 1'b0);
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_empty: got %b want 1", bus.ready_o); end
    @(negedge clk);
    drive(32'd200, 32'd2, 1'b0);
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_one: got %b want 1", bus.ready_o); end
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL bp_valid_one: got %b want 0", bus.valid_o); end
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      if (t == 1) drive(32'd999, 32'd7, 1'b1);
      else drive(32'd300, 32'd3, 1'b0);
      checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL bp_hold%0d_ready: got %b want 0", t, bus.ready_o); end
      checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL bp_hold%0d_valid: got %b want 1", t, bus.valid_o); end
      checks++; if (bus.diff_o !== 32'd99) begin errors++; $display("FAIL bp_hold%0d_diff: got %0d want 99", t, bus.diff_o); end
    end
    @(negedge clk);
    bus.ready_i = 1'b1;
    #1;
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", bus.ready_o); end
    checks++; if (bus.diff_o !== 32'd99) begin errors++; $display("FAIL bp_release_diff: got %0d want 99", bus.diff_o); end
    @(posedge clk);
    #1 bus.valid_i = 1'b0;
    @(negedge clk);
    checks++; if (bus.valid_o !== 1'b1 || bus.diff_o !== 32'd198) begin errors++; $display("FAIL bp_out1: got v=%b d=%0d want v=1 d=198", bus.valid_o, bus.diff_o); end
    @(negedge clk);
    checks++; if (bus.valid_o !== 1'b1 || bus.diff_o !== 32'd297) begin errors++; $display("FAIL bp_out2: got v=%b d=%0d want v=1 d=297", bus.valid_o, bus.diff_o); end
    @(negedge clk);
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b want 0", bus.valid_o); end
  endtask

  task automatic test_reset_midstream();
    bus.ready_i = 1'b0;
    @(negedge clk);
    drive(32'd7, 32'd2, 1'b0);
    @(negedge clk);
    drive(32'd9, 32'd4, 1'b0);
    @(negedge clk);
    bus.valid_i = 1'b0;
    checks++; if (bus.valid_o !== 1'b1 || bus.ready_o !== 1'b0) begin errors++; $display("FAIL mid_full: got v=%b r=%b want v=1 r=0", bus.valid_o, bus.ready_o); end
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", bus.valid_o); end
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b want 1", bus.ready_o); end
    checks++; if (bus.diff_o !== '0) begin errors++; $display("FAIL mid_rst_diff: got %h want 0", bus.diff_o); end
    @(posedge clk);
    @(negedge clk);
    rst_ni      = 1'b1;
    bus.ready_i = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL mid_stale: got %b want 0", bus.valid_o); end
    drive(32'd50, 32'd8, 1'b1);
    @(posedge clk);
    #1 bus.valid_i = 1'b0;
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL post_rst_early: got %b want 0", bus.valid_o); end
    @(posedge clk);
    #1;
    checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL post_rst_valid: got %b want 1", bus.valid_o); end
    checks++; if (bus.diff_o !== 32'd41) begin errors++; $display("FAIL post_rst_diff: got %0d want 41", bus.diff_o); end
  endtask

  initial begin
    bus.valid_i = 1'b0;
    bus.a_i     = '0;
    bus.b_i     = '0;
    bus.bin_i   = 1'b0;
    bus.ready_i = 1'b0;
    test_reset();
    test_arith();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
